truth_table_scan: RTL and testbench
===================================

TRUTH_TABLE_SCAN -- requirements
Module: truth_table_scan

Interface
REQ-001 SHALL provide parameter SETTLE, default 2, meaning cycles each vector is held before z is sampled (legal 1..15).
REQ-002 SHALL provide port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port: start  input  1  request a full 32-vector scan.
REQ-005 SHALL provide port: z  input  1  response from the combinational block under scan.
REQ-006 SHALL provide ports: a, b, c, d, e  output  1 each  stimulus vector, {a,b,c,d,e} = idx, a is MSB.
REQ-007 SHALL provide port: busy  output  1  high while a scan is in progress.
REQ-008 SHALL provide port: done  output  1  one-cycle pulse at scan completion.
REQ-009 SHALL provide port: table  output  32  captured truth table, bit i = z sampled for vector i.
REQ-010 SHALL provide port: ones  output  6  count of 1s captured in table, range 0..32.

Function
REQ-011 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-012 SHALL, in IDLE with start=1, clear table and ones, set idx=0 and settle count=0, and enter DRIVE.
REQ-013 SHALL drive {a,b,c,d,e}=idx in DRIVE and SAMPLE; drive 0 in IDLE and DONE.
REQ-014 SHALL remain in DRIVE for exactly SETTLE cycles, then enter SAMPLE.
REQ-015 SHALL, in SAMPLE, write z into table[idx] and add z to ones; if idx==31 go to DONE, else increment idx, clear settle count and go to DRIVE.
REQ-016 SHALL hold each vector for SETTLE+1 cycles; done SHALL rise exactly 1+32*(SETTLE+1) cycles after the edge on which start was sampled.
REQ-017 SHALL assert done only in DONE (one cycle), then return to IDLE.
REQ-018 SHALL assert busy only in DRIVE and SAMPLE; busy and done SHALL never be high together.
REQ-019 SHALL ignore start while busy or in DONE; no restart, no effect on the scan.
REQ-020 SHALL hold table and ones stable from DONE until the next accepted start.
REQ-021 SHALL accept start in the IDLE cycle immediately after DONE (back-to-back scans).
REQ-022 SHALL NOT wrap idx; the scan terminates at idx 31 and no vector is visited twice.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, enter IDLE with idx=0, settle count=0, a..e=0, busy=0, done=0, table=0, ones=0.
REQ-024 SHALL give rst priority over start and over any in-progress scan; a mid-scan reset discards partial results.

Configuration
REQ-025 SHALL support macro SCAN_PARITY_EN.
REQ-026 SHALL, when SCAN_PARITY_EN is defined, add port parity  output  1  = XOR of all 32 table bits, valid from DONE and reset to 0.
REQ-027 SHALL, when SCAN_PARITY_EN is undefined, omit the parity port and logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: SETTLE=2, z = a^b^c^d^e, one start pulse -> done at cycle 97, table=32'h96696996, ones=16, parity=0 if enabled.
REQ-029 SHALL cover: z tied 0 -> table=0, ones=0; z tied 1 -> table=32'hFFFFFFFF, ones=32.
REQ-030 SHALL cover: SETTLE=1, z = a&b&c&d&e -> done at cycle 65, table=32'h80000000, ones=1, parity=1 if enabled.
REQ-031 SHALL cover: start held high for the whole scan -> exactly one scan, single done pulse, next scan begins only in the IDLE cycle after DONE.
REQ-032 SHALL cover: rst asserted at idx=10 -> next cycle IDLE, all outputs 0; fresh start then completes a normal scan with correct table.
REQ-033 SHALL cover: each vector idx 0..31 is observed on {a,b,c,d,e} for exactly SETTLE+1 consecutive cycles, in ascending order.

Source files
------------

// File: rtl/truth_table_scan_if.sv
// Handshake and result bundle for truth_table_scan.
//   master : the requester / block-under-scan side (drives start and z)
//   slave  : the scanner itself (drives the stimulus vector and results)
// Signals:
//   start      - request a full 32-vector scan
//   z          - response of the combinational block under scan
//   a..e       - stimulus vector, {a,b,c,d,e} = current index, a is MSB
//   busy       - scan in progress
//   done       - one-cycle pulse at scan completion
//   scan_table - captured truth table, bit i = z for vector i
//                (named scan_table because "table" is a reserved word)
//   ones       - number of 1s in scan_table (0..32)
//   parity     - XOR of all scan_table bits, only with SCAN_PARITY_EN
interface truth_table_scan_if;
  logic        start;
  logic        z;
  logic        a, b, c, d, e;
  logic        busy;
  logic        done;
  logic [31:0] scan_table;
  logic [5:0]  ones;
`ifdef SCAN_PARITY_EN
  logic        parity;

  modport master (output start, z,
                  input  a, b, c, d, e, busy, done, scan_table, ones, parity);
  modport slave  (input  start, z,
                  output a, b, c, d, e, busy, done, scan_table, ones, parity);
`else
  modport master (output start, z,
                  input  a, b, c, d, e, busy, done, scan_table, ones);
  modport slave  (input  start, z,
                  output a, b, c, d, e, busy, done, scan_table, ones);
`endif
endinterface

// File: rtl/truth_table_scan.sv
// truth_table_scan: walks a 5-input combinational block through all 32
// input vectors, holds each vector SETTLE+1 cycles and captures the response
// z into a 32-bit truth table together with a population count.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - truth_table_scan_if.slave (start, z in; a..e, busy, done,
//          scan_table, ones [, parity] out)
// Parameters:
//   SETTLE - cycles a vector is held before z is sampled (legal 1..15)
// Optional feature:
//   SCAN_PARITY_EN - when defined, bus.parity = XOR of all table bits
module truth_table_scan #(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  truth_table_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state, state_n;
  logic [4:0]  idx;
  logic [3:0]  settle_cnt;
  logic [31:0] scan_table;
  logic [5:0]  ones;
  logic [4:0]  vec;
  logic        busy;
  logic        done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = DRIVE;
      DRIVE:   if (settle_cnt == SETTLE_LAST) state_n = SAMPLE;
      SAMPLE:  state_n = (idx == 5'd31) ? DONE : DRIVE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the visible vector,
  // busy and done trail the state register by one cycle. The vector index
  // is constant across DRIVE and SAMPLE, so the block under scan still sees
  // each vector for SETTLE cycles before z is taken in SAMPLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      scan_table <= '0;
      ones       <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vec  <= (state == DRIVE || state == SAMPLE) ? idx : 5'd0;
      busy <= (state == DRIVE || state == SAMPLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            scan_table <= '0;
            ones       <= '0;
            idx        <= '0;
            settle_cnt <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 4'd1;
        end
        SAMPLE: begin
          scan_table[idx] <= bus.z;
          ones            <= ones + 6'(bus.z);
          // idx stops at 31; DONE follows and no vector is revisited.
          if (idx != 5'd31) begin
            idx        <= idx + 5'd1;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d, bus.e} = vec;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.scan_table = scan_table;
  assign bus.ones       = ones;

`ifdef SCAN_PARITY_EN
  // Table is cleared on reset and on start, so parity is 0 then and final
  // once the last SAMPLE has written its bit.
  assign bus.parity = ^scan_table;
`endif

endmodule

// File: tb/tb_truth_table_scan.sv
module tb_truth_table_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  int          mode;
  logic [31:0] pat;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  truth_table_scan_if if0 ();
  truth_table_scan_if if1 ();

  truth_table_scan #(.SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  truth_table_scan #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Block under scan: 0 const0, 1 const1, 2 xor, 3 and, 4 lookup pattern
  function automatic logic zfn(input int m, input logic [31:0] p, input logic [4:0] v);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ^v;
      3:       return &v;
      default: return p[v];
    endcase
  endfunction

  assign if0.start = start0;
  assign if1.start = start1;
  assign if0.z = zfn(mode, pat, {if0.a, if0.b, if0.c, if0.d, if0.e});
  assign if1.z = zfn(mode, pat, {if1.a, if1.b, if1.c, if1.d, if1.e});

  // Reference: expected truth table computed from the rule per index.
  function automatic logic [31:0] model_table(input int m, input logic [31:0] p);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < 32; i++) begin
      case (m)
        0:       t[i] = 1'b0;
        1:       t[i] = 1'b1;
        2:       t[i] = ($countones(i) % 2) == 1;
        3:       t[i] = (i == 31);
        default: t[i] = p[i];
      endcase
    end
    return t;
  endfunction

  function automatic logic [4:0] obs_vec(input bit s);
    return s ? {if1.a, if1.b, if1.c, if1.d, if1.e} : {if0.a, if0.b, if0.c, if0.d, if0.e};
  endfunction
  function automatic logic obs_busy(input bit s);
    return s ? if1.busy : if0.busy;
  endfunction
  function automatic logic obs_done(input bit s);
    return s ? if1.done : if0.done;
  endfunction
  function automatic logic [31:0] obs_table(input bit s);
    return s ? if1.scan_table : if0.scan_table;
  endfunction
  function automatic logic [5:0] obs_ones(input bit s);
    return s ? if1.ones : if0.ones;
  endfunction
`ifdef SCAN_PARITY_EN
  function automatic logic obs_parity(input bit s);
    return s ? if1.parity : if0.parity;
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  task automatic check_all_zero(input bit s, input string tag);
    check({tag, "_vec"},   obs_vec(s),   0);
    check({tag, "_busy"},  obs_busy(s),  0);
    check({tag, "_done"},  obs_done(s),  0);
    check({tag, "_table"}, obs_table(s), 0);
    check({tag, "_ones"},  obs_ones(s),  0);
`ifdef SCAN_PARITY_EN
    check({tag, "_parity"}, obs_parity(s), 0);
`endif
  endtask

  // One full scan from IDLE. Edge 0 is the edge sampling start; cycle n is
  // observed 1 time unit after edge n. Expected: busy in cycles 1..D,
  // vector (n-1)/(SETTLE+1), done only in cycle D+1, D = 32*(SETTLE+1).
  // Without hold, start is randomly toggled through the scan and DONE to
  // show it is ignored.
  task automatic scan(input bit s, input bit hold, input string tag,
                      output logic [31:0] got_table, output logic [5:0] got_ones);
    int settle, per, dn, vec_err, busy_err, done_err;
    logic [31:0] et;
    settle   = s ? 1 : 2;
    per      = settle + 1;
    dn       = 1 + 32 * per;
    vec_err  = 0;
    busy_err = 0;
    done_err = 0;
    et = model_table(mode, pat);
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk);
    for (int n = 1; n <= dn; n++) begin
      @(negedge clk);
      if (!hold) set_start(s, 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      if (obs_vec(s)  !== ((n < dn) ? 5'((n - 1) / per) : 5'd0)) vec_err++;
      if (obs_busy(s) !== (n < dn))  busy_err++;
      if (obs_done(s) !== (n == dn)) done_err++;
    end
    check({tag, "_vec_seq_errs"},  vec_err,  0);
    check({tag, "_busy_errs"},     busy_err, 0);
    check({tag, "_done_timing"},   done_err, 0);
    check({tag, "_table"},         obs_table(s), et);
    check({tag, "_ones"},          obs_ones(s),  $countones(et));
`ifdef SCAN_PARITY_EN
    check({tag, "_parity"},        obs_parity(s), ^et);
`endif
    got_table = obs_table(s);
    got_ones  = obs_ones(s);
    if (hold) begin
      // start still high: accepted in the IDLE cycle right after DONE
      @(posedge clk);
      #1;
      check({tag, "_gap_busy"},  obs_busy(s),  0);
      check({tag, "_gap_done"},  obs_done(s),  0);
      check({tag, "_restart_clear"}, obs_table(s), 0);
      @(negedge clk);
      set_start(s, 1'b0);
      @(posedge clk);
      #1;
      check({tag, "_restart_busy"}, obs_busy(s), 1);
      check({tag, "_restart_vec"},  obs_vec(s),  0);
    end else begin
      @(negedge clk);
      set_start(s, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_hold_table"}, obs_table(s), et);
      check({tag, "_hold_ones"},  obs_ones(s),  $countones(et));
      check({tag, "_idle_busy"},  obs_busy(s),  0);
    end
  endtask

  typedef struct {
    int          mode;
    bit          sel;
    logic [31:0] tbl;
    int          ones;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] gt;
    logic [5:0]  go;
    bit          hit;

    vecs[0] = '{2, 1'b0, 32'h96696996, 16};
    vecs[1] = '{0, 1'b0, 32'h00000000, 0};
    vecs[2] = '{1, 1'b0, 32'hFFFFFFFF, 32};
    vecs[3] = '{3, 1'b1, 32'h80000000, 1};
    vecs[4] = '{2, 1'b1, 32'h96696996, 16};
    vecs[5] = '{1, 1'b1, 32'hFFFFFFFF, 32};

    rst    = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    mode   = 0;
    pat    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero(1'b0, "reset0");
    check_all_zero(1'b1, "reset1");
    @(negedge clk);
    rst    = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 6; k++) begin
      mode = vecs[k].mode;
      scan(vecs[k].sel, 1'b0, $sformatf("vec%0d", k), gt, go);
      check($sformatf("vec%0d_const_table", k), gt, vecs[k].tbl);
      check($sformatf("vec%0d_const_ones", k),  go, vecs[k].ones);
    end

    for (int r = 0; r < 4; r++) begin
      mode = 4;
      pat  = $urandom;
      scan(1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", r), gt, go);
    end

    mode = 2;
    scan(1'b0, 1'b1, "hold", gt, go);

    // Reset in the middle of a scan, once vector 10 is on the outputs.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    mode = 4;
    pat  = $urandom;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk);
      #1;
      if (obs_vec(1'b0) == 5'd10) hit = 1'b1;
    end
    check("midrst_reached_idx10", hit, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero(1'b0, "midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero(1'b0, "midrst_idle");
    scan(1'b0, 1'b0, "after_rst", gt, go);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
